// File: rtl/hazard_stall_unit.sv
// Pipeline hazard controller: load-use bubbles, data-memory wait freeze and taken-branch flushes.
// Optional HAZARD_PERF_CNT_EN adds the stall_cycles / flush_events performance counters.
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  RUN       | no multi-cycle hazard in progress; evaluate inputs directly
//  BUBBLE    | inserting extra load-use bubbles (bub_cnt counts them)
//  MEM_WAIT  | pipeline frozen waiting on data memory (wait_cnt counts)
module hazard_stall_unit #(
    parameter int LOAD_BUBBLES = 1,
    parameter int MAX_WAIT     = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] id_r1,
    input  logic [3:0] id_r2,
    input  logic       id_uses_r1,
    input  logic       id_uses_r2,
    input  logic [3:0] ex_rdest,
    input  logic       ex_regw,
    input  logic       ex_mem_read,
    input  logic       mem_req,
    input  logic       mem_ready,
    input  logic       branch_taken,
    output logic       stall_if,
    output logic       stall_id,
    output logic       stall_back,
    output logic       flush_if_id,
    output logic       flush_id_ex,
    output logic       mem_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_events
`endif
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_BUBBLE   = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;

    localparam logic [1:0] BUB_LAST = 2'(LOAD_BUBBLES - 1);
    localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

    logic [1:0] state, state_nx;
    logic [1:0] bub_cnt, bub_cnt_nx;
    logic [7:0] wait_cnt, wait_cnt_nx;
    logic       ret_bub, ret_bub_nx;
    logic       timeout_set;
    logic       load_use, mem_stall;
    logic       s_if, s_id, s_back, f_ifid, f_idex;

    assign load_use = ex_mem_read & ex_regw &
                      ((id_uses_r1 & (id_r1 == ex_rdest)) |
                       (id_uses_r2 & (id_r2 == ex_rdest)));
    assign mem_stall = mem_req & ~mem_ready;

    always_comb begin
        state_nx    = state;
        bub_cnt_nx  = bub_cnt;
        wait_cnt_nx = wait_cnt;
        ret_bub_nx  = ret_bub;
        timeout_set = 1'b0;
        s_if        = 1'b0;
        s_id        = 1'b0;
        s_back      = 1'b0;
        f_ifid      = 1'b0;
        f_idex      = 1'b0;
        case (state)
            ST_RUN: begin
                if (mem_stall) begin
                    {s_if, s_id, s_back} = 3'b111;
                    state_nx    = ST_MEM_WAIT;
                    wait_cnt_nx = 8'd1;
                    ret_bub_nx  = 1'b0;
                end else if (branch_taken) begin
                    {f_ifid, f_idex} = 2'b11;
                end else if (load_use) begin
                    {s_if, s_id, f_idex} = 3'b111;
                    if (LOAD_BUBBLES > 1) begin
                        state_nx   = ST_BUBBLE;
                        bub_cnt_nx = 2'd1;
                    end
                end
            end
            ST_BUBBLE: begin
                // bub_cnt is left untouched so the bubble sequence resumes after the wait
                if (mem_stall) begin
                    {s_if, s_id, s_back} = 3'b111;
                    state_nx    = ST_MEM_WAIT;
                    wait_cnt_nx = 8'd1;
                    ret_bub_nx  = 1'b1;
                end else if (branch_taken) begin
                    {f_ifid, f_idex} = 2'b11;
                    state_nx   = ST_RUN;
                    bub_cnt_nx = 2'd0;
                end else begin
                    {s_if, s_id, f_idex} = 3'b111;
                    if (bub_cnt == BUB_LAST) begin
                        state_nx   = ST_RUN;
                        bub_cnt_nx = 2'd0;
                    end else begin
                        bub_cnt_nx = bub_cnt + 2'd1;
                    end
                end
            end
            ST_MEM_WAIT: begin
                // EX is frozen here, so branch_taken is deliberately ignored
                if (mem_ready) begin
                    state_nx = ret_bub ? ST_BUBBLE : ST_RUN;
                end else if (wait_cnt == WAIT_MAX) begin
                    timeout_set = 1'b1;
                    state_nx    = ret_bub ? ST_BUBBLE : ST_RUN;
                end else begin
                    {s_if, s_id, s_back} = 3'b111;
                    if (wait_cnt < WAIT_MAX) wait_cnt_nx = wait_cnt + 8'd1;
                end
            end
            default: state_nx = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            bub_cnt     <= 2'd0;
            wait_cnt    <= 8'd0;
            ret_bub     <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            state    <= state_nx;
            bub_cnt  <= bub_cnt_nx;
            wait_cnt <= wait_cnt_nx;
            ret_bub  <= ret_bub_nx;
            if (timeout_set) mem_timeout <= 1'b1;
        end
    end

    // Outputs are forced low while reset is held, regardless of the inputs.
    assign stall_if    = s_if   & rst_n;
    assign stall_id    = s_id   & rst_n;
    assign stall_back  = s_back & rst_n;
    assign flush_if_id = f_ifid & rst_n;
    assign flush_id_ex = f_idex & rst_n;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= 32'd0;
            flush_events <= 16'd0;
        end else begin
            if (stall_if)    stall_cycles <= stall_cycles + 32'd1;
            if (flush_if_id) flush_events <= flush_events + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed testbench for hazard_stall_unit (LOAD_BUBBLES=2, MAX_WAIT=15).
module tb_hazard_stall_unit;

    logic       clk, rst_n;
    logic [3:0] id_r1, id_r2, ex_rdest;
    logic       id_uses_r1, id_uses_r2, ex_regw, ex_mem_read;
    logic       mem_req, mem_ready, branch_taken;
    logic       stall_if, stall_id, stall_back, flush_if_id, flush_id_ex, mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_events;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    hazard_stall_unit #(.LOAD_BUBBLES(2), .MAX_WAIT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_r1(id_r1), .id_r2(id_r2),
        .id_uses_r1(id_uses_r1), .id_uses_r2(id_uses_r2),
        .ex_rdest(ex_rdest), .ex_regw(ex_regw), .ex_mem_read(ex_mem_read),
        .mem_req(mem_req), .mem_ready(mem_ready), .branch_taken(branch_taken),
        .stall_if(stall_if), .stall_id(stall_id), .stall_back(stall_back),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .mem_timeout(mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] r1;
        logic [3:0] r2;
        logic       u1;
        logic       u2;
        logic [3:0] rd;
        logic       regw;
        logic       mrd;
        logic       mreq;
        logic       mrdy;
        logic       br;
        logic [4:0] exp;   // {stall_if, stall_id, stall_back, flush_if_id, flush_id_ex}
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [4:0] exp);
        logic [4:0] got;
        got = {stall_if, stall_id, stall_back, flush_if_id, flush_id_ex};
        total_cnt++;
        if (got !== exp)
            $display("FAIL %s: outputs got %b expected %b (t=%0t)", name, got, exp, $time);
        else
            pass_cnt++;
    endtask

    task automatic chk_to(input string name, input logic exp);
        total_cnt++;
        if (mem_timeout !== exp)
            $display("FAIL %s: mem_timeout got %b expected %b", name, mem_timeout, exp);
        else
            pass_cnt++;
    endtask

    task automatic set_idle();
        id_r1 = 4'd0; id_r2 = 4'd0; id_uses_r1 = 1'b0; id_uses_r2 = 1'b0;
        ex_rdest = 4'd0; ex_regw = 1'b0; ex_mem_read = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b1; branch_taken = 1'b0;
    endtask

    task automatic set_vec(input vec_t v);
        id_r1 = v.r1; id_r2 = v.r2; id_uses_r1 = v.u1; id_uses_r2 = v.u2;
        ex_rdest = v.rd; ex_regw = v.regw; ex_mem_read = v.mrd;
        mem_req = v.mreq; mem_ready = v.mrdy; branch_taken = v.br;
    endtask

    task automatic set_loaduse();
        set_idle();
        id_r1 = 4'd1; id_r2 = 4'd5; id_uses_r1 = 1'b1; id_uses_r2 = 1'b1;
        ex_rdest = 4'd5; ex_regw = 1'b1; ex_mem_read = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //                name            r1     r2    u1    u2    rd    regw  mrd   mreq  mrdy  br    exp
        vecs[0]  = '{"idle",          4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00000};
        vecs[1]  = '{"lu_r2",         4'd1, 4'd5, 1'b1, 1'b1, 4'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'b11001};
        vecs[2]  = '{"imm_r2",        4'd1, 4'd5, 1'b1, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'b00000};
        vecs[3]  = '{"not_load",      4'd1, 4'd5, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00000};
        vecs[4]  = '{"no_regw",       4'd1, 4'd5, 1'b1, 1'b1, 4'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'b00000};
        vecs[5]  = '{"lu_r0",         4'd0, 4'd9, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'b11001};
        vecs[6]  = '{"branch",        4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'b00011};
        vecs[7]  = '{"br_over_lu",    4'd1, 4'd5, 1'b1, 1'b1, 4'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'b00011};
        vecs[8]  = '{"mem_stall",     4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b11100};
        vecs[9]  = '{"mem_over_all",  4'd1, 4'd5, 1'b1, 1'b1, 4'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'b11100};
        vecs[10] = '{"mem_ready_hit", 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'b00000};
        vecs[11] = '{"r1_unused",     4'd7, 4'd3, 1'b0, 1'b1, 4'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'b00000};
        vecs[12] = '{"lu_r15",        4'd15,4'd2, 1'b1, 1'b1, 4'd15,1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'b11001};

        rst_n = 1'b0;
        set_idle();
        mem_req = 1'b1; mem_ready = 1'b0;   // hazard present while reset held
        #3;
        chk("reset_outs", 5'b00000);
        chk_to("reset_timeout", 1'b0);
        set_idle();
        #4 rst_n = 1'b1;
        tick();

        for (int i = 0; i < 13; i++) begin
            set_vec(vecs[i]);
            #1;
            chk(vecs[i].name, vecs[i].exp);
            set_idle();
            repeat (3) tick();
        end

        // load-use with two bubbles
        set_loaduse(); #1; chk("lu_bub1", 5'b11001);
        tick();                 chk("lu_bub2", 5'b11001);
        tick(); ex_mem_read = 1'b0; #1; chk("lu_after", 5'b00000);
        set_idle(); repeat (2) tick();

        // memory wait of 4 cycles
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1; chk("memwait_stall", 5'b11100);
            tick();
        end
        mem_ready = 1'b1; #1; chk("memwait_release", 5'b00000);
        tick(); set_idle(); #1; chk("memwait_run", 5'b00000);
        chk_to("memwait_no_timeout", 1'b0);
        tick();

        // timeout: 15 stall cycles, then forced release
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            #1; chk("timeout_stall", 5'b11100);
            tick();
        end
        #1; chk("timeout_release", 5'b00000);
        chk_to("timeout_pre_edge", 1'b0);
        tick(); set_idle(); #1;
        chk_to("timeout_set", 1'b1);
        chk("timeout_run", 5'b00000);
        repeat (3) tick();
        chk_to("timeout_sticky", 1'b1);

        // branch in second bubble cycle
        set_loaduse(); #1; chk("brbub_1", 5'b11001);
        tick(); branch_taken = 1'b1; #1; chk("brbub_flush", 5'b00011);
        tick(); set_idle(); #1; chk("brbub_after", 5'b00000);
        tick();

        // memory wait interrupting a bubble, bubble resumes afterwards
        set_loaduse(); #1; chk("membub_1", 5'b11001);
        tick(); set_idle(); mem_req = 1'b1; mem_ready = 1'b0; #1; chk("membub_wait", 5'b11100);
        tick(); mem_ready = 1'b1; #1; chk("membub_release", 5'b00000);
        tick(); set_idle(); #1; chk("membub_resume", 5'b11001);
        tick(); #1; chk("membub_done", 5'b00000);
        tick();

        // async reset in the middle of a memory wait
        mem_req = 1'b1; mem_ready = 1'b0;
        tick(); tick();
        #1; chk("arst_pre", 5'b11100);
        #1 rst_n = 1'b0;
        #1; chk("arst_outs", 5'b00000);
        chk_to("arst_timeout_clr", 1'b0);
`ifdef HAZARD_PERF_CNT_EN
        total_cnt++;
        if (stall_cycles !== 32'd0 || flush_events !== 16'd0)
            $display("FAIL perf_reset: got %0d/%0d expected 0/0", stall_cycles, flush_events);
        else
            pass_cnt++;
`endif
        set_idle();
        #1 rst_n = 1'b1;
        tick(); #1; chk("arst_run_idle", 5'b00000);
        set_loaduse(); #1; chk("arst_run_lu", 5'b11001);
        chk_to("arst_timeout_stays", 1'b0);
        set_idle(); repeat (3) tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Pipeline hazard controller. It handles every hazard the EX-stage forwarding muxes cannot resolve: load-use RAW, data-memory wait states, and taken-branch flushes.
- Sits beside the ID/EX and EX/MEM pipeline registers.
- Drives stall (hold) and flush (bubble) controls back into IF/ID, ID/EX and EX/MEM, the opposite direction from forwarding, which pushes results forward.
- An FSM plus counters sequence multi-cycle bubbles and memory waits.

Parameters:
- LOAD_BUBBLES, 1, bubbles inserted per load-use hazard (1..3); 2 when load data is only forwardable from WB.
- MAX_WAIT, 15, maximum memory wait cycles before forced release (1..255).

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- id_r1, id_r2  in  4  source register indexes of the instruction in ID
- id_uses_r1, id_uses_r2  in  1  ID instruction actually reads r1 / r2; low for branch target or immediate operand
- ex_rdest  in  4  destination register of the instruction in EX
- ex_regw  in  1  EX instruction writes the register file
- ex_mem_read  in  1  EX instruction is a load
- mem_req  in  1  MEM stage holds a load/store access this cycle
- mem_ready  in  1  data memory completes the access this cycle
- branch_taken  in  1  EX resolved a taken branch
- stall_if  out  1  hold PC
- stall_id  out  1  hold IF/ID register
- stall_back  out  1  hold ID/EX, EX/MEM and MEM/WB (memory wait freeze)
- flush_if_id  out  1  clear IF/ID to NOP
- flush_id_ex  out  1  clear ID/EX to NOP
- mem_timeout  out  1  sticky: a memory wait hit MAX_WAIT

Behaviour:
- Reset: rst_n low at any time (async) puts state in RUN, clears bub_cnt and wait_cnt, and clears mem_timeout. All outputs read 0 while rst_n is low.
- Control outputs are combinational from the registered state plus the current inputs, so they are valid in the same cycle as the hazard. State, counters and mem_timeout update on the rising edge of clk.
- Load-use hit: ex_mem_read & ex_regw & ((id_uses_r1 & id_r1==ex_rdest) | (id_uses_r2 & id_r2==ex_rdest)). All 16 register indexes are compared, R0 included.
- Memory stall condition: mem_req & !mem_ready.
- State RUN:
  - memory stall: stall_if = stall_id = stall_back = 1, go to MEM_WAIT, wait_cnt = 1.
  - else branch_taken: flush_if_id = flush_id_ex = 1, stay in RUN.
  - else load-use hit: stall_if = stall_id = flush_id_ex = 1. If LOAD_BUBBLES > 1, go to BUBBLE with bub_cnt = 1; else stay in RUN.
  - else all outputs 0.
- State BUBBLE:
  - outputs stall_if = stall_id = flush_id_ex = 1; bub_cnt increments.
  - returns to RUN in the cycle bub_cnt == LOAD_BUBBLES-1, for exactly LOAD_BUBBLES total bubble cycles.
  - branch_taken: the flush overrides the bubble, giving flush_if_id = flush_id_ex = 1, stalls 0, go to RUN.
  - memory stall: MEM_WAIT takes priority; bub_cnt is held and resumed afterwards via a return flag.
- State MEM_WAIT:
  - stall_if = stall_id = stall_back = 1; flushes are 0 (branch_taken is ignored because EX is frozen).
  - mem_ready = 1: release this cycle with all stalls 0, go to the saved return state (RUN or BUBBLE).
  - wait_cnt == MAX_WAIT without mem_ready: set mem_timeout, release as above.
  - wait_cnt saturates at MAX_WAIT.
- Priority, highest first: memory wait > branch flush > load-use.
- A second hazard in the cycle right after release is evaluated normally; there is no dead cycle.
- mem_timeout is cleared only by reset.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds outputs stall_cycles[31:0] and flush_events[15:0].
  - stall_cycles increments every cycle that stall_if is 1.
  - flush_events increments on every branch flush.
  - Both wrap on overflow and reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Load-use: EX load to r5 with ex_regw=1, ID reads r5 on r2 with id_uses_r2=1, LOAD_BUBBLES=2 -> stall_if/stall_id/flush_id_ex high for exactly 2 cycles, then 0.
- Non-hazard: ID uses r5 but id_uses_r2=0 (immediate), or ex_mem_read=0 -> all outputs 0.
- Memory wait: mem_req=1, mem_ready low for 4 cycles then high -> stall_back high for 4 cycles and low in the mem_ready cycle; mem_timeout stays 0.
- Timeout: MAX_WAIT=15, mem_ready never asserted -> released after 15 stall cycles, mem_timeout=1 and stays set until rst_n low.
- Branch during bubble: branch_taken=1 in the second bubble cycle -> flush_if_id=flush_id_ex=1 that cycle, stalls 0, next cycle all outputs 0.
- Async reset mid MEM_WAIT: rst_n low between clock edges -> all outputs 0 immediately; after release, state RUN and mem_timeout=0.
